// File: rtl/mux_n_scan.sv
// Registered N:1 channel multiplexer with manual select and round-robin auto scan.
// In auto mode each channel is held for DWELL edges; o_wrap pulses on the NCH-1 -> 0 advance.
module mux_n_scan #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DWELL = 8,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_mode,
  input  logic [SELW-1:0]        i_sel,
  input  logic                   i_hold,
  input  logic [NCH*WIDTH-1:0]   i_data,
  output logic [WIDTH-1:0]       o_f,
  output logic [SELW-1:0]        o_ch,
  output logic                   o_valid,
  output logic                   o_wrap
);

  // Counter is at least one bit wide so DWELL=1 still builds.
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW-1:0] LastCh  = SELW'(NCH - 1);
  localparam logic [CW-1:0]   LastCnt = CW'(DWELL - 1);

  logic [WIDTH-1:0] chans [NCH];
  logic [WIDTH-1:0] f_q, f_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             sel_ok;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      chans[k] = i_data[k*WIDTH +: WIDTH];
    end
  end

  // Select values >= NCH exist only when NCH is not a power of two.
  assign sel_ok = (32'(i_sel) < NCH);

  always_comb begin
    f_d     = '0;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (!i_mode) begin
      cnt_d = '0;
      if (sel_ok) begin
        ch_d    = i_sel;
        f_d     = chans[i_sel];
        valid_d = 1'b1;
      end
    end else begin
      valid_d = 1'b1;
      if (!i_hold) begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (ch_q == LastCh) begin
            ch_d   = '0;
            wrap_d = 1'b1;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      f_d = chans[ch_d];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f_q     <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      f_q     <= f_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_f     = f_q;
  assign o_ch    = ch_q;
  assign o_valid = valid_q;
  assign o_wrap  = wrap_q;

endmodule
